// File: rtl/pc_pkg.sv
// Shared types for the fetch-stage program counter: widths, address type and
// the next-address source encoding.
package pc_pkg;

    localparam int PC_W   = 10;
    localparam int OFS_W  = 8;
    localparam int PAGE_W = PC_W - OFS_W;

    typedef logic [PC_W-1:0] pc_t;

    typedef enum logic [2:0] {
        PC_INC,
        PC_START,
        PC_CALL,
        PC_RET,
        PC_LJ,
        PC_JMP,
        PC_BR
    } pc_src_e;

endpackage

// File: rtl/pc_next_sel.sv
// Priority encoder choosing where the next program-counter value comes from,
// plus the page index for long jumps.
module pc_next_sel
    import pc_pkg::*;
(
    input  logic              start_i,
    input  logic              jump2sub_i,
    input  logic              retfsub_i,
    input  logic [3:0]        lj_i,
    input  logic              branch_i,
    input  logic              jmp_i,
    input  logic              br_i,
    output pc_src_e           src_o,
    output logic [PAGE_W-1:0] page_o
);

    always_comb begin
        src_o  = PC_INC;
        page_o = '0;
        // Lowest long-jump index wins when several page strobes are set.
        if (lj_i[0]) begin
            page_o = 2'd0;
        end else if (lj_i[1]) begin
            page_o = 2'd1;
        end else if (lj_i[2]) begin
            page_o = 2'd2;
        end else if (lj_i[3]) begin
            page_o = 2'd3;
        end

        if (start_i) begin
            src_o = PC_START;
        end else if (jump2sub_i) begin
            src_o = PC_CALL;
        end else if (retfsub_i) begin
            src_o = PC_RET;
        end else if (|lj_i) begin
            src_o = PC_LJ;
        end else if (branch_i && jmp_i) begin
            src_o = PC_JMP;
        end else if (branch_i && br_i) begin
            src_o = PC_BR;
        end
    end

endmodule

// File: rtl/program_counter.sv
// Fetch-stage program counter: registered 10-bit address updated every clock
// from the source picked by pc_next_sel.
module program_counter
    import pc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             branch,
    input  logic             jizr,
    input  logic             jnzr,
    input  logic             bizr,
    input  logic             bnzr,
    input  logic             jump2sub,
    input  logic             retFsub,
    input  logic             lj0,
    input  logic             lj1,
    input  logic             lj2,
    input  logic             lj3,
    input  logic [OFS_W-1:0] rz,
    input  logic [PC_W-1:0]  start_address,
    input  logic [PC_W-1:0]  subroutine,
    input  logic [PC_W-1:0]  rl,
    input  logic [PC_W-1:0]  res,
    output logic [PC_W-1:0]  rp
);

    pc_src_e           src;
    logic [PAGE_W-1:0] lj_page;
    pc_t               rp_d;
    pc_t               rp_q = '0;

    pc_next_sel u_sel (
        .start_i    (start),
        .jump2sub_i (jump2sub),
        .retfsub_i  (retFsub),
        .lj_i       ({lj3, lj2, lj1, lj0}),
        .branch_i   (branch),
        .jmp_i      (jizr | jnzr),
        .br_i       (bizr | bnzr),
        .src_o      (src),
        .page_o     (lj_page)
    );

    always_comb begin
        rp_d = rp_q + pc_t'(1);
        case (src)
            PC_START: rp_d = start_address;
            PC_CALL:  rp_d = subroutine;
            PC_RET:   rp_d = rl;
            PC_LJ:    rp_d = {lj_page, rz};
            PC_JMP:   rp_d = res;
            // In-page branch keeps the current page bits.
            PC_BR:    rp_d = {rp_q[PC_W-1:OFS_W], rz};
            default:  rp_d = rp_q + pc_t'(1);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rp_q <= '0;
        end else begin
            rp_q <= rp_d;
        end
    end

    assign rp = rp_q;

endmodule

// File: tb/tb_program_counter.sv
// Directed checks of program_counter source selection, priority and wrap.
module tb_program_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       branch = 1'b0;
    logic       jizr = 1'b0;
    logic       jnzr = 1'b0;
    logic       bizr = 1'b0;
    logic       bnzr = 1'b0;
    logic       jump2sub = 1'b0;
    logic       retFsub = 1'b0;
    logic       lj0 = 1'b0;
    logic       lj1 = 1'b0;
    logic       lj2 = 1'b0;
    logic       lj3 = 1'b0;
    logic [7:0] rz = '0;
    logic [9:0] start_address = '0;
    logic [9:0] subroutine = '0;
    logic [9:0] rl = '0;
    logic [9:0] res = '0;
    logic [9:0] rp;

    int err_cnt = 0;
    int chk_cnt = 0;

    always #5 clk = ~clk;

    program_counter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .branch        (branch),
        .jizr          (jizr),
        .jnzr          (jnzr),
        .bizr          (bizr),
        .bnzr          (bnzr),
        .jump2sub      (jump2sub),
        .retFsub       (retFsub),
        .lj0           (lj0),
        .lj1           (lj1),
        .lj2           (lj2),
        .lj3           (lj3),
        .rz            (rz),
        .start_address (start_address),
        .subroutine    (subroutine),
        .rl            (rl),
        .res           (res),
        .rp            (rp)
    );

    task automatic check_eq(input string tag, input logic [9:0] got, input logic [9:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: rp=0x%03h expected 0x%03h", tag, got, exp);
        end
    endtask

    task automatic clear_ctrl();
        rst_n = 1'b1;
        start = 1'b0;
        branch = 1'b0;
        jizr = 1'b0;
        jnzr = 1'b0;
        bizr = 1'b0;
        bnzr = 1'b0;
        jump2sub = 1'b0;
        retFsub = 1'b0;
        lj0 = 1'b0;
        lj1 = 1'b0;
        lj2 = 1'b0;
        lj3 = 1'b0;
    endtask

    // Apply the currently set controls across one rising edge, then check rp.
    task automatic tick(input string tag, input logic [9:0] exp);
        @(posedge clk);
        #1;
        check_eq(tag, rp, exp);
        clear_ctrl();
    endtask

    initial begin
        #1;
        check_eq("powerup", rp, 10'h000);

        rst_n = 1'b0; tick("reset", 10'h000);
        tick("inc1", 10'h001);
        tick("inc2", 10'h002);

        branch = 1'b1; jizr = 1'b1; res = 10'h3FF; tick("preload_3ff", 10'h3FF);
        tick("wrap", 10'h000);

        start = 1'b1; start_address = 10'h100; tick("start", 10'h100);
        start = 1'b1; jump2sub = 1'b1; start_address = 10'h155; subroutine = 10'h21C;
        tick("start_over_call", 10'h155);

        branch = 1'b1; jizr = 1'b1; res = 10'h0CC; tick("jizr", 10'h0CC);
        branch = 1'b1; bnzr = 1'b1; rz = 8'hF0; tick("bnzr_page0", 10'h0F0);
        branch = 1'b1; jnzr = 1'b1; res = 10'h2CC; tick("jnzr", 10'h2CC);
        branch = 1'b1; bizr = 1'b1; rz = 8'hF0; tick("bizr_page2", 10'h2F0);
        jizr = 1'b1; res = 10'h055; tick("jizr_not_taken", 10'h2F1);
        bnzr = 1'b1; rz = 8'h10; tick("bnzr_not_taken", 10'h2F2);
        branch = 1'b1; tick("branch_alone", 10'h2F3);

        jump2sub = 1'b1; subroutine = 10'h21C; tick("call", 10'h21C);
        retFsub = 1'b1; rl = 10'h2A0; tick("ret", 10'h2A0);
        jump2sub = 1'b1; retFsub = 1'b1; subroutine = 10'h133; rl = 10'h2A0;
        tick("call_over_ret", 10'h133);

        rz = 8'hF0;
        lj0 = 1'b1; tick("lj0", 10'h0F0);
        lj1 = 1'b1; tick("lj1", 10'h1F0);
        lj2 = 1'b1; tick("lj2", 10'h2F0);
        lj3 = 1'b1; tick("lj3", 10'h3F0);
        lj1 = 1'b1; lj3 = 1'b1; tick("lj1_lj3", 10'h1F0);
        rz = 8'h3C; lj2 = 1'b1; lj3 = 1'b1; tick("lj2_lj3", 10'h23C);
        retFsub = 1'b1; rl = 10'h077; lj2 = 1'b1; tick("ret_over_lj", 10'h077);
        lj3 = 1'b1; rz = 8'h05; branch = 1'b1; jizr = 1'b1; res = 10'h111;
        tick("lj_over_jmp", 10'h305);
        branch = 1'b1; jnzr = 1'b1; bizr = 1'b1; res = 10'h1AB; rz = 8'h99;
        tick("jmp_over_br", 10'h1AB);

        rst_n = 1'b0; jump2sub = 1'b1; subroutine = 10'h21C; tick("reset_mid", 10'h000);
        tick("after_reset", 10'h001);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/program_counter.md
Name: program_counter

Overview:
- 10-bit program counter for the 9-bit CPU fetch stage. It drives the instruction memory address `rp`.
- Each clock it selects the next address from one of these sources: sequential increment, start vector, register jump, in-page branch, long jump (page + 8-bit target), subroutine call target, or subroutine return (link) address.
- Control strobes come from the decoder. The branch-condition flag comes from the datapath.

Parameters:
- PC_W, 10, program-counter / address width.
- OFS_W, 8, width of the in-page target `rz`; page field width = PC_W-OFS_W (2).

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  load start vector.
- branch  in  1  condition-true flag qualifying jizr/jnzr/bizr/bnzr.
- jizr  in  1  jump-if-zero-register instruction decoded.
- jnzr  in  1  jump-if-nonzero-register instruction decoded.
- bizr  in  1  branch-if-zero-register instruction decoded.
- bnzr  in  1  branch-if-nonzero-register instruction decoded.
- jump2sub  in  1  subroutine call.
- retFsub  in  1  return from subroutine.
- lj0, lj1, lj2, lj3  in  1 each  long jump into page 0/1/2/3.
- rz  in  8  in-page target byte.
- start_address  in  10  reset/start vector.
- subroutine  in  10  subroutine entry address.
- rl  in  10  link (return) address.
- res  in  10  full register-jump target.
- rp  out  10  current program counter.

Behaviour:
- Single clock domain. `rp` is a register updated on every rising `clk`; no stall/enable input.
- Reset: `rst_n`=0 at a rising edge -> `rp` <= 0. Reset has priority over all other inputs. Reset mid-operation discards any pending control.
- Power-up/initial value of `rp` is 0, so simulation without reset starts at 0.
- Next-value selection, strict priority, highest first:
  1. `start` -> `start_address`.
  2. `jump2sub` -> `subroutine`.
  3. `retFsub` -> `rl`.
  4. `lj0`/`lj1`/`lj2`/`lj3` -> {2'd0/1/2/3, `rz`}. If several are set, the lowest index wins.
  5. `branch` & (`jizr`|`jnzr`) -> `res`.
  6. `branch` & (`bizr`|`bnzr`) -> {`rp`[9:8], `rz`}, i.e. stay in the current page and replace the low 8 bits.
  7. Otherwise -> `rp`+1, modulo 2^10 (1023 wraps to 0).
- `jizr`/`jnzr`/`bizr`/`bnzr` with `branch`=0 are not taken: PC increments.
- `branch`=1 with no jump/branch strobe set has no effect: PC increments.
- Zero/nonzero evaluation is external. The block treats the `jizr`/`jnzr` pair, and the `bizr`/`bnzr` pair, identically.
- Latency: a selection made in cycle N is visible on `rp` after edge N+1. There is no combinational path from inputs to `rp`.
- The block stores no link address; the caller supplies `rl`.

Decomposition:
- Shared package `pc_pkg`:
  - PC_W, OFS_W localparams.
  - typedef `pc_t` (logic [PC_W-1:0]).
  - enum `pc_src_e` {PC_INC, PC_START, PC_CALL, PC_RET, PC_LJ, PC_JMP, PC_BR}.
- One natural sub-module, `pc_next_sel`: combinational priority encoder producing `pc_src_e` and the long-jump page index.
- Top level holds the next-PC mux and the register.

Test Plan:
- Reset then free-run: `rst_n`=0 for one edge -> `rp`=0; release -> `rp`=1, then 2, one per edge. Also preload `rp`=1023 via `res`, increment -> 0.
- Start: `start`=1, `start_address`=0x100 -> `rp`=0x100. Repeat with `start` and `jump2sub` together -> `start` wins.
- Jump/branch:
  - `branch`=1, `jizr`=1, `res`=0x0CC -> `rp`=0x0CC.
  - Next cycle `branch`=1, `bnzr`=1, `rz`=0xF0 -> `rp`=0x0F0 (page 0 kept).
  - From `rp`=0x2CC, the same branch -> 0x2F0.
  - `branch`=0 with `jizr`=1 -> `rp` increments.
- Subroutine: `jump2sub`=1, `subroutine`=0x21C -> `rp`=0x21C; then `retFsub`=1, `rl`=0x2A0 -> `rp`=0x2A0.
- Long jumps, `rz`=0xF0: `lj0` -> 0x0F0, `lj1` -> 0x1F0, `lj2` -> 0x2F0, `lj3` -> 0x3F0. `lj1`+`lj3` together -> 0x1F0.
- Reset mid-sequence: `rst_n`=0 while `jump2sub`=1 -> `rp`=0.
